// File: rtl/hash_job_scheduler_pkg.sv
// Shared types and widths for the hash job scheduler: FSM states, bus widths and
// the difficulty-target compare.
package hash_job_scheduler_pkg;

   localparam int unsigned NonceW  = 32;
   localparam int unsigned HashW   = 24;
   localparam int unsigned BlockW  = 96;
   localparam int unsigned TargetW = 8;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StDrain,
      StReport
   } state_e;

   // Only the two upper hash bytes take part in the difficulty test.
   function automatic logic hash_hit(logic [7:0] hi, logic [7:0] mid, logic [TargetW-1:0] target);
      return (hi < target) && (mid < target);
   endfunction

endpackage

// File: rtl/hash_job_scheduler_if.sv
// Job request, shared-core and result signals of the hash job scheduler.
interface hash_job_scheduler_if;
   import hash_job_scheduler_pkg::*;

   logic [1:0]         job_valid;
   logic [1:0]         job_ready;
   logic [BlockW-1:0]  job_bloque0;
   logic [BlockW-1:0]  job_bloque1;
   logic [TargetW-1:0] job_target0;
   logic [TargetW-1:0] job_target1;
   logic [BlockW-1:0]  core_bloque;
   logic [NonceW-1:0]  core_nonce;
   logic [HashW-1:0]   core_hash;
   logic               res_valid;
   logic               res_id;
   logic               res_found;
   logic [NonceW-1:0]  res_nonce;
   logic [HashW-1:0]   res_hash;
   logic               busy;

   modport master (
      input  job_valid, job_bloque0, job_bloque1, job_target0, job_target1, core_hash,
      output job_ready, core_bloque, core_nonce, res_valid, res_id, res_found, res_nonce,
             res_hash, busy
   );

   modport slave (
      output job_valid, job_bloque0, job_bloque1, job_target0, job_target1, core_hash,
      input  job_ready, core_bloque, core_nonce, res_valid, res_id, res_found, res_nonce,
             res_hash, busy
   );

endinterface

// File: rtl/hash_tag_pipe.sv
// In-flight tracker: a Depth-deep {valid, nonce} shift register that lines each
// returning core hash up with the nonce that produced it.
module hash_tag_pipe import hash_job_scheduler_pkg::*; #(
   parameter int unsigned Depth = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic [NonceW-1:0] push_nonce,
   output logic              tag_valid,
   output logic [NonceW-1:0] tag_nonce,
   output logic              empty
);

   logic [Depth-1:0]             valid_q;
   logic [Depth-1:0][NonceW-1:0] nonce_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         nonce_q <= '0;
      end else begin
         valid_q[0] <= push & ~flush;
         nonce_q[0] <= push_nonce;
         for (int unsigned i = 1; i < Depth; i++) begin
            valid_q[i] <= valid_q[i-1] & ~flush;
            nonce_q[i] <= nonce_q[i-1];
         end
      end
   end

   assign tag_valid = valid_q[Depth-1];
   assign tag_nonce = nonce_q[Depth-1];
   assign empty     = ~|valid_q;

endmodule

// File: rtl/hash_job_scheduler.sv
// Round-robin nonce-search scheduler for two requesters sharing one fixed-latency
// hash core; reports the first qualifying nonce or search exhaustion.
module hash_job_scheduler import hash_job_scheduler_pkg::*; #(
   parameter int unsigned       HASH_LAT  = 3,
   parameter logic [NonceW-1:0] NONCE_MAX = 32'hFFFF_FFFF
) (
   input logic                  clk,
   input logic                  reset,
   hash_job_scheduler_if.master bus
);

   state_e             state_q;
   logic               rr_q;
   logic               id_q;
   logic [TargetW-1:0] target_q;
   logic [BlockW-1:0]  core_bloque_q;
   logic [NonceW-1:0]  core_nonce_q;
   logic [HashW-1:0]   last_hash_q;
   logic               res_valid_q;
   logic               res_id_q;
   logic               res_found_q;
   logic [NonceW-1:0]  res_nonce_q;
   logic [HashW-1:0]   res_hash_q;

   logic              winner;
   logic [1:0]        grant;
   logic              tag_valid;
   logic              tag_empty;
   logic [NonceW-1:0] tag_nonce;
   logic              match_now;
   logic              push;
   logic              flush;

   always_comb begin
      winner = bus.job_valid[1];
      if (bus.job_valid == 2'b11) winner = rr_q;
   end

   // Ready is offered only while idle so a job is accepted at the end of the IDLE cycle.
   assign grant = (state_q == StIdle && !reset && |bus.job_valid) ? (2'b01 << winner) : 2'b00;

   assign match_now = tag_valid &&
                      hash_hit(bus.core_hash[23:16], bus.core_hash[15:8], target_q);
   assign push      = (state_q == StRun) && !match_now;
   assign flush     = (state_q == StLoad) || match_now;

   hash_tag_pipe #(
      .Depth (HASH_LAT)
   ) u_tag_pipe (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (push),
      .push_nonce (core_nonce_q),
      .tag_valid  (tag_valid),
      .tag_nonce  (tag_nonce),
      .empty      (tag_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         rr_q          <= 1'b0;
         id_q          <= 1'b0;
         target_q      <= '0;
         core_bloque_q <= '0;
         core_nonce_q  <= '0;
         last_hash_q   <= '0;
         res_valid_q   <= 1'b0;
         res_id_q      <= 1'b0;
         res_found_q   <= 1'b0;
         res_nonce_q   <= '0;
         res_hash_q    <= '0;
      end else begin
         res_valid_q <= 1'b0;
         if (tag_valid) last_hash_q <= bus.core_hash;
         unique case (state_q)
            StIdle: begin
               if (|bus.job_valid) begin
                  id_q          <= winner;
                  rr_q          <= ~winner;
                  target_q      <= winner ? bus.job_target1 : bus.job_target0;
                  core_bloque_q <= winner ? bus.job_bloque1 : bus.job_bloque0;
                  state_q       <= StLoad;
               end
            end
            StLoad: begin
               core_nonce_q <= '0;
               state_q      <= StRun;
            end
            StRun, StDrain: begin
               // A returning match takes precedence over reaching the last nonce.
               if (match_now) begin
                  res_valid_q <= 1'b1;
                  res_id_q    <= id_q;
                  res_found_q <= 1'b1;
                  res_nonce_q <= tag_nonce;
                  res_hash_q  <= bus.core_hash;
                  state_q     <= StReport;
               end else if (state_q == StRun) begin
                  if (core_nonce_q == NONCE_MAX) state_q <= StDrain;
                  else core_nonce_q <= core_nonce_q + 32'd1;
               end else if (tag_empty) begin
                  res_valid_q <= 1'b1;
                  res_id_q    <= id_q;
                  res_found_q <= 1'b0;
                  res_nonce_q <= NONCE_MAX;
                  res_hash_q  <= last_hash_q;
                  state_q     <= StReport;
               end
            end
            StReport: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

   assign bus.job_ready   = grant;
   assign bus.core_bloque = core_bloque_q;
   assign bus.core_nonce  = core_nonce_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_id      = res_id_q;
   assign bus.res_found   = res_found_q;
   assign bus.res_nonce   = res_nonce_q;
   assign bus.res_hash    = res_hash_q;
   assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_hash_job_scheduler.sv
// Randomized bench for hash_job_scheduler: a table-driven core model and a
// first-match reference search predict grant order, result and timing of every job.
module tb_hash_job_scheduler;

   localparam int unsigned L    = 3;
   localparam int          NMAX = 15;

   logic clk;
   logic reset;

   hash_job_scheduler_if bus ();

   hash_job_scheduler #(
      .HASH_LAT  (L),
      .NONCE_MAX (32'(NMAX))
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: hash for each nonce comes from a per-job table, L cycles later.
   logic [23:0] hash_tab [16];
   logic [23:0] core_pipe [L];

   always @(posedge clk) begin
      core_pipe[0] <= hash_tab[bus.core_nonce[3:0]];
      for (int i = 1; i < int'(L); i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign bus.core_hash = core_pipe[L-1];

   int checks;
   int errors;
   int rr;
   bit hold;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] miss_hash(input logic [7:0] t);
      logic [23:0] h;
      h = 24'($urandom);
      if ($urandom_range(1, 0) == 0) h[23:16] = 8'($urandom_range(255, int'(t)));
      else h[15:8] = 8'($urandom_range(255, int'(t)));
      return h;
   endfunction

   function automatic logic [23:0] hit_hash(input logic [7:0] t);
      logic [23:0] h;
      h = 24'($urandom);
      h[23:16] = 8'($urandom_range(int'(t) - 1, 0));
      h[15:8]  = 8'($urandom_range(int'(t) - 1, 0));
      return h;
   endfunction

   task automatic fill_zero();
      for (int n = 0; n < 16; n++) hash_tab[n] = 24'h0;
   endtask

   // Only nonce k qualifies against target t (k < 0: none does).
   task automatic fill_only(input int k, input logic [7:0] t);
      for (int n = 0; n < 16; n++) hash_tab[n] = (n == k) ? hit_hash(t) : miss_hash(t);
   endtask

   task automatic fill_random();
      for (int n = 0; n < 16; n++) hash_tab[n] = 24'($urandom);
   endtask

   task automatic post(input int i, input logic [7:0] t);
      logic [95:0] b;
      b = {$urandom, $urandom, $urandom};
      if (i == 0) begin
         bus.job_bloque0 = b;
         bus.job_target0 = t;
      end else begin
         bus.job_bloque1 = b;
         bus.job_target1 = t;
      end
      bus.job_valid[i] = 1'b1;
   endtask

   task automatic rst_checks();
      check("rst_job_ready", bus.job_ready, 0);
      check("rst_core_bloque", bus.core_bloque, 0);
      check("rst_core_nonce", bus.core_nonce, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_id", bus.res_id, 0);
      check("rst_res_found", bus.res_found, 0);
      check("rst_res_nonce", bus.res_nonce, 0);
      check("rst_res_hash", bus.res_hash, 0);
      check("rst_busy", bus.busy, 0);
   endtask

   // Waits for a grant, predicts the job outcome, follows it to its result.
   // abort_at >= 0 pulses reset when that nonce is on core_nonce.
   task automatic do_job(input int abort_at);
      int          cyc, win, lat, exp_lat, exp_n, exp_cn, stray, pulses;
      bit          exp_f, hit;
      logic [7:0]  tgt;
      logic [95:0] blk;
      logic [23:0] exp_h;
      cyc = 0;
      #1;
      while (bus.job_ready == 2'b00 && cyc < 40) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("grant_seen", bus.job_ready != 2'b00, 1);
      if (bus.job_ready == 2'b00) return;
      win = (bus.job_valid == 2'b11) ? rr : (bus.job_valid[1] ? 1 : 0);
      check("grant", bus.job_ready, 2'b01 << win);
      rr  = 1 - win;
      tgt = win ? bus.job_target1 : bus.job_target0;
      blk = win ? bus.job_bloque1 : bus.job_bloque0;

      exp_f = 1'b0;
      exp_n = NMAX;
      exp_h = hash_tab[NMAX];
      for (int n = 0; n <= NMAX; n++) begin
         hit = (hash_tab[n][23:16] < tgt) && (hash_tab[n][15:8] < tgt);
         if (hit && !exp_f) begin
            exp_f = 1'b1;
            exp_n = n;
            exp_h = hash_tab[n];
         end
      end
      exp_lat = exp_f ? exp_n + int'(L) + 3 : NMAX + int'(L) + 4;
      exp_cn  = (exp_f && exp_n + int'(L) < NMAX) ? exp_n + int'(L) : NMAX;

      stray = 0;
      for (lat = 1; lat < 80; lat++) begin
         @(negedge clk);
         if (lat == 1) begin
            if (!hold) bus.job_valid[win] = 1'b0;
            check("busy_load", bus.busy, 1);
         end
         if (bus.job_ready != 2'b00) stray++;
         if (lat == 2) begin
            check("first_nonce", bus.core_nonce, 0);
            check("bloque", bus.core_bloque, blk);
         end
         if (abort_at >= 0 && lat == abort_at + 2) begin
            check("abort_nonce", bus.core_nonce, abort_at);
            bus.job_valid = 2'b00;
            reset = 1'b1;
            #1;
            rst_checks();
            @(negedge clk);
            reset  = 1'b0;
            rr     = 0;
            pulses = 0;
            repeat (L + 4) begin
               @(negedge clk);
               if (bus.res_valid) pulses++;
            end
            check("abort_no_res", pulses, 0);
            return;
         end
         if (bus.res_valid) break;
      end
      check("latency", lat, exp_lat);
      check("no_stray_grant", stray, 0);
      check("res_id", bus.res_id, win);
      check("res_found", bus.res_found, exp_f);
      check("res_nonce", bus.res_nonce, exp_n);
      check("res_hash", bus.res_hash, exp_h);
      check("stop_nonce", bus.core_nonce, exp_cn);
      check("bloque_held", bus.core_bloque, blk);
      @(negedge clk);
      check("res_pulse", bus.res_valid, 0);
      check("res_hold", bus.res_nonce, exp_n);
      check("busy_idle", bus.busy, 0);
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rr              = 0;
      hold            = 1'b0;
      reset           = 1'b1;
      bus.job_valid   = 2'b00;
      bus.job_bloque0 = '0;
      bus.job_bloque1 = '0;
      bus.job_target0 = '0;
      bus.job_target1 = '0;
      fill_zero();
      repeat (3) @(negedge clk);
      rst_checks();
      reset = 1'b0;
      @(negedge clk);

      post(0, 8'hFF);
      fill_zero();
      do_job(-1);

      post(1, 8'h80);
      fill_only(5, 8'h80);
      do_job(-1);

      post(0, 8'h40);
      fill_only(-1, 8'h40);
      do_job(-1);

      post(0, 8'h20);
      fill_only(15, 8'h20);
      do_job(-1);

      post(1, 8'h10);
      fill_only(12, 8'h10);
      do_job(-1);

      hold = 1'b1;
      post(0, 8'h70);
      post(1, 8'hC0);
      for (int j = 0; j < 4; j++) begin
         fill_random();
         do_job(-1);
      end
      bus.job_valid = 2'b00;
      hold          = 1'b0;
      @(negedge clk);

      post(0, 8'h00);
      fill_only(-1, 8'h00);
      do_job(10);

      post(0, 8'h90);
      post(1, 8'h30);
      fill_random();
      do_job(-1);

      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 2; i++) begin
            if (!bus.job_valid[i] && $urandom_range(1, 0) == 1)
               post(i, 8'($urandom_range(255, 0)));
         end
         if (bus.job_valid == 2'b00) post(int'($urandom_range(1, 0)), 8'($urandom_range(255, 0)));
         fill_random();
         do_job(-1);
      end

      bus.job_valid = 2'b00;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hash_job_scheduler.md
HASH_JOB_SCHEDULER -- requirements
Module: hash_job_scheduler

Interface
REQ-001 Parameter HASH_LAT, default 3, fixed cycles from core_nonce/core_bloque presented to matching core_hash valid (1..8).
REQ-002 Parameter NONCE_MAX, default 32'hFFFF_FFFF, last nonce searched per job.
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 job_valid  in  2  per-requester job request (index 0, 1).
REQ-006 job_ready  out  2  one-hot grant; job accepted on job_valid[i] & job_ready[i].
REQ-007 job_bloque0, job_bloque1  in  96 each  block bytes per requester.
REQ-008 job_target0, job_target1  in  8 each  difficulty target per requester.
REQ-009 core_bloque  out  96  block bytes driven to the shared hash core.
REQ-010 core_nonce  out  32  nonce driven to the shared hash core.
REQ-011 core_hash  in  24  hash returned by core, HASH_LAT cycles after issue.
REQ-012 res_valid  out  1  one-cycle result pulse.
REQ-013 res_id  out  1  requester owning the result.
REQ-014 res_found  out  1  1 = qualifying nonce found, 0 = search exhausted.
REQ-015 res_nonce  out  32  winning nonce (last issued nonce if not found).
REQ-016 res_hash  out  24  hash for res_nonce.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, LOAD, RUN, DRAIN, REPORT; encoding in shared package.
REQ-019 IDLE: if any job_valid, assert job_ready for exactly one cycle to the round-robin winner; go LOAD.
REQ-020 Round-robin: after serving requester i, requester 1-i has priority; simultaneous requests after reset grant requester 0.
REQ-021 LOAD: latch granted bloque, target, id; clear nonce counter to 0; clear in-flight tracker; go RUN.
REQ-022 RUN: issue one nonce per cycle on core_nonce, incrementing by 1, core_bloque held constant for the whole job.
REQ-023 In-flight tracker: HASH_LAT-deep shift register of {valid, nonce}; a result is checked only when its tag valid bit is set.
REQ-024 Match rule: core_hash[23:16] < target AND core_hash[15:8] < target, unsigned 8-bit compare; core_hash[7:0] ignored.
REQ-025 On first match in RUN or DRAIN: capture nonce and hash, stop issuing, invalidate all remaining tags, go REPORT with found=1.
REQ-026 When the issued nonce equals NONCE_MAX: stop issuing (no wrap to 0), go DRAIN.
REQ-027 DRAIN: keep checking returning tags; when tracker empty without match go REPORT with found=0, res_nonce=NONCE_MAX, res_hash=last returned hash.
REQ-028 Match and NONCE_MAX issue in the same cycle: match wins, go REPORT found=1.
REQ-029 REPORT: res_valid high one cycle with res_id/found/nonce/hash; next state IDLE; res_* hold values until next REPORT.
REQ-030 job_valid deasserting mid-job has no effect; job completes.
REQ-031 job_ready is never asserted outside IDLE; no two grants without an intervening REPORT.
REQ-032 Latency from acceptance to first core_nonce: 2 cycles (LOAD, then RUN first cycle).

Reset
REQ-033 reset asserted at any time forces IDLE immediately, aborts any job without res_valid, clears tracker.
REQ-034 Reset values: job_ready=0, core_bloque=0, core_nonce=0, res_valid=0, res_id=0, res_found=0, res_nonce=0, res_hash=0, busy=0, round-robin pointer=requester 0.

Structure
REQ-035 Shared package holds FSM state constants, nonce width 32, hash width 24, block width 96.
REQ-036 One sub-module natural: hash_tag_pipe (HASH_LAT-deep valid/nonce shift register with flush input).
REQ-037 Hash core instantiated outside; this block connects only via core_* ports.

Verification
REQ-038 Single job req0, target 8'hFF, core model always returns 24'h000000 -> res_valid after LOAD+RUN+HASH_LAT, found=1, res_nonce=0, res_id=0.
REQ-039 Core model matches only nonce 5 with HASH_LAT=3 -> res_nonce=5, nonces 6..7 discarded, exactly one res_valid.
REQ-040 NONCE_MAX=15, core never matches -> nonces 0..15 issued once, no wrap, res_found=0, res_nonce=15.
REQ-041 job_valid=2'b11 held continuously -> grants alternate 0,1,0,1; res_id follows the same order.
REQ-042 reset pulsed in RUN at nonce 10 -> outputs at reset values, no res_valid, next job starts at nonce 0.
REQ-043 Match on nonce NONCE_MAX in the cycle it is returned -> found=1, res_nonce=NONCE_MAX.
